mio_bus_v2: RTL

Parametrised memory-mapped I/O bus between the single-cycle CPU and its peripherals: the VGA text buffer, the PS/2 keyboard receiver, and a display/LED output register pair. It replaces the purely combinational address/data mux with four pieces of state:
- address-region decode;
- a buffered keyboard scan-code FIFO with pop-on-read and sticky overflow;
- CPU-writable display and LED registers;
- an unmapped-access error flag.

---
 rtl/mio_bus_v2.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/mio_bus_v2.sv
// rtl/mio_bus_v2.sv - memory-mapped I/O bus: VGA, keyboard FIFO, display/LED registers, error flag
// Region decode on address bits [31:28]; all read data is combinational for the single-cycle CPU.

module mio_kbd_fifo #(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [7:0]               data,
   input  logic                     pop,
   output logic [7:0]               head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full,
   output logic                     drop
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic          pop_ok;
   logic          push_ok;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign pop_ok  = pop & ~empty;
   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
   assign push_ok = push & (~full | pop_ok);
   assign drop    = push & full & ~pop_ok;
   assign head    = mem[rptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push_ok)
            wptr <= wptr + AW'(1);
         if (pop_ok)
            rptr <= rptr + AW'(1);
         count <= count + CW'(push_ok) - CW'(pop_ok);
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok && !rst)
         mem[wptr] <= data;
   end
endmodule

module mio_bus_v2 #(
   parameter int DATA_W    = 32,
   parameter int VGA_RD_W  = 7,
   parameter int KBD_DEPTH = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [31:0]         cpu_mem_a,
   input  logic [DATA_W-1:0]   d_t_mem,
   output logic [DATA_W-1:0]   d_f_mem,
   input  logic                cpu_rd,
   input  logic                cpu_wr,
   output logic [31:0]         vga_a,
   output logic [DATA_W-1:0]   d_t_vga,
   input  logic [VGA_RD_W-1:0] d_f_vga,
   output logic                wvram,
   input  logic                kbd_valid,
   input  logic [7:0]          kbd_data,
   output logic [31:0]         disp_num,
   output logic [7:0]          led,
   output logic                bus_err
);
   localparam int CW = $clog2(KBD_DEPTH) + 1;

   logic [3:0]    region;
   logic          sel_vga;
   logic          sel_kdata;
   logic          sel_kstat;
   logic          sel_out;
   logic          unmapped;
   logic          rd_eff;
   logic          ovf;
   logic          ready;
   logic          full;
   logic          empty;
   logic          drop;
   logic [7:0]    head;
   logic [CW-1:0] count;
   logic [31:0]   wd32;
   logic [31:0]   rd32;

   assign region    = cpu_mem_a[31:28];
   assign sel_vga   = (region == 4'hC);
   assign sel_kdata = (region == 4'hD);
   assign sel_kstat = (region == 4'hE);
   assign sel_out   = (region == 4'hF);
   assign unmapped  = (region[3:2] != 2'b11);
   // A simultaneous write takes the bus; the read then has no side effects.
   assign rd_eff    = cpu_rd & ~cpu_wr;
   assign ready     = ~empty;
   assign wd32      = 32'(d_t_mem);

   assign vga_a   = cpu_mem_a;
   assign d_t_vga = d_t_mem;
   assign wvram   = cpu_wr & sel_vga;

   mio_kbd_fifo #(.DEPTH(KBD_DEPTH)) u_kbd_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (kbd_valid),
      .data  (kbd_data),
      .pop   (rd_eff & sel_kdata),
      .head  (head),
      .count (count),
      .empty (empty),
      .full  (full),
      .drop  (drop)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         ovf      <= 1'b0;
         bus_err  <= 1'b0;
         disp_num <= '0;
         led      <= '0;
      end else begin
         if (drop)
            ovf <= 1'b1;
         else if (rd_eff && sel_kstat)
            ovf <= 1'b0;
         if ((cpu_rd || cpu_wr) && unmapped)
            bus_err <= 1'b1;
         if (cpu_wr && sel_out) begin
            if (cpu_mem_a[2])
               led <= wd32[7:0];
            else
               disp_num <= wd32;
         end
      end
   end

   always_comb begin
      rd32 = '0;
      if (sel_vga)
         rd32 = 32'(d_f_vga);
      else if (sel_kdata)
         rd32 = ready ? {23'h0, 1'b1, head} : 32'h0;
      else if (sel_kstat)
         rd32 = {8'h0, 8'(count), 6'h0, ovf, ready, 8'h0};
      else if (sel_out)
         rd32 = cpu_mem_a[2] ? {24'h0, led} : disp_num;
   end

   assign d_f_mem = DATA_W'(rd32);
endmodule
